// File: rtl/prisc_pkg.sv
// Shared pRISC datapath constants and types. The write-address selector,
// the control unit and the register file all take RA_IDX / SP_IDX from here
// so the architectural register roles are defined in exactly one place.
package prisc_pkg;

  // Architectural register file geometry.
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 32;

  // Named register roles.
  localparam int unsigned RA_IDX = 31;  // return address (jal target of the selector)
  localparam int unsigned SP_IDX = 30;  // stack pointer

  // Stack pointer starts at the top word of the 1 KB data memory.
  localparam logic [DATA_W-1:0] SP_RESET = 32'h0000_03FC;

  typedef logic [DATA_W-1:0]       word_t;
  typedef logic [ADDR_W-1:0]       reg_idx_t;
  typedef word_t [REG_COUNT-1:0]   reg_array_t;

  // Full register image loaded on reset: all zero except the stack pointer.
  function automatic reg_array_t reset_image();
    reg_array_t img;
    img         = '0;
    img[SP_IDX] = SP_RESET;
    return img;
  endfunction

endpackage : prisc_pkg

// File: rtl/reg_file_if.sv
// Register file port bundle: two read ports and one write port.
//
// Protocol: there is no valid/ready handshake. A write is a single-cycle
// command: when wr_en is high at a rising clock edge (and reset is not
// asserted) wr_data is committed to wr_addr; the register file can always
// accept it, so no ready/back-pressure exists. Read ports are combinational:
// rd_dataN follows rd_addrN in the same cycle, including a pending write to
// the same index (write-before-read bypass).
interface reg_file_if;
  import prisc_pkg::*;

  reg_idx_t rd_addr1;
  reg_idx_t rd_addr2;
  word_t    rd_data1;
  word_t    rd_data2;
  logic     wr_en;
  reg_idx_t wr_addr;
  word_t    wr_data;

  // Datapath / decode side: issues read indices and the write-back command.
  modport master (
    output rd_addr1,
    output rd_addr2,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data1,
    input  rd_data2
  );

  // Register file side.
  modport slave (
    input  rd_addr1,
    input  rd_addr2,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data1,
    output rd_data2
  );

endinterface : reg_file_if

// File: rtl/reg_read_port.sv
// One combinational read port: array index plus write-before-read bypass.
// byp_en already folds in "reset deasserted and a write is pending", so this
// module only has to compare indices.
module reg_read_port
  import prisc_pkg::*;
(
  input  reg_array_t regs,
  input  reg_idx_t   rd_addr,
  input  logic       byp_en,
  input  reg_idx_t   wr_addr,
  input  word_t      wr_data,
  output word_t      rd_data
);

  logic hit;

  assign hit = byp_en && (wr_addr == rd_addr);

  // Select the stored value, overridden by the in-flight write on an index match.
  always_comb begin
    rd_data = regs[rd_addr];
    if (hit) begin
      rd_data = wr_data;
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// pRISC architectural register file: 32 x DATA_W flops, two combinational
// read ports with write-before-read bypass, one synchronous write port.
// Register 0 is an ordinary writable register. Reset (synchronous,
// active-low) loads zero everywhere except the stack pointer and wins over
// any write presented in the same cycle.
module reg_file
  import prisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  reg_array_t regs;
  logic       byp_en;

  // The bypass is only meaningful when the write will actually commit,
  // i.e. not in a reset cycle, where the write is discarded.
  assign byp_en = rst && bus.wr_en;

  // Register array update: reset image has priority over the write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= reset_image();
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_read_port u_rd_port1 (
    .regs    (regs),
    .rd_addr (bus.rd_addr1),
    .byp_en  (byp_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd_data1)
  );

  reg_read_port u_rd_port2 (
    .regs    (regs),
    .rd_addr (bus.rd_addr2),
    .byp_en  (byp_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd_data2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vectors with literal expected
// values, plus a behavioural array model compared on every cycle.
module tb_reg_file;

  logic clk;
  logic rst;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];
  bit          model_valid = 1'b0;
  logic [31:0] exp_q [$];

  // Behavioural meaning of a read: pending committed write wins, else the array.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (rst === 1'b1 && bus.wr_en === 1'b1 && bus.wr_addr == a)
      return bus.wr_data;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge from the inputs held stable across it.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 30) ? 32'h0000_03FC : 32'h0;
      model_valid = 1'b1;
    end else if (bus.wr_en === 1'b1) begin
      model[bus.wr_addr] = bus.wr_data;
    end
  end

  // Every-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      exp_q.push_back(model_read(bus.rd_addr1));
      exp_q.push_back(model_read(bus.rd_addr2));
      check("model_port1", bus.rd_data1, exp_q.pop_front());
      check("model_port2", bus.rd_data2, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst          = r;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
  endtask

  // Advance to mid-cycle for literal checks.
  task automatic to_mid();
    @(negedge clk);
  endtask

  // Advance past the next rising edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    drive(1'b1, 1'b1, wa, wd, 5'd0, 5'd0);
    next_edge();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    next_edge();
    next_edge();

    // 1) reset state sweep on both ports
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      to_mid();
      check("reset_sweep_p1", bus.rd_data1, (i == 30) ? 32'h0000_03FC : 32'h0);
      check("reset_sweep_p2", bus.rd_data2, (i == 1) ? 32'h0000_03FC : 32'h0);
      next_edge();
    end

    // 2) write 31, read back on both ports next cycle
    write_reg(5'd31, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    to_mid();
    check("ra_read_p1", bus.rd_data1, 32'hDEAD_BEEF);
    check("ra_read_p2", bus.rd_data2, 32'hDEAD_BEEF);
    next_edge();

    // 3) same-cycle bypass on port 1 only; port 2 sees old value of 6
    drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd6);
    to_mid();
    check("bypass_p1", bus.rd_data1, 32'h1234_5678);
    check("no_bypass_p2", bus.rd_data2, 32'h0);
    next_edge();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    to_mid();
    check("after_bypass_p1", bus.rd_data1, 32'h1234_5678);
    next_edge();

    // 4) wr_en low: no write, no bypass
    write_reg(5'd7, 32'h0707_0707);
    drive(1'b1, 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7);
    to_mid();
    check("wr_dis_nobyp", bus.rd_data1, 32'h0707_0707);
    next_edge();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    to_mid();
    check("wr_dis_kept", bus.rd_data1, 32'h0707_0707);
    next_edge();

    // 5) register 0 is writable
    write_reg(5'd0, 32'h0000_0042);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    to_mid();
    check("r0_writable", bus.rd_data2, 32'h0000_0042);
    next_edge();

    // Both ports bypass at once; back-to-back writes, last edge wins
    drive(1'b1, 1'b1, 5'd12, 32'h0000_0001, 5'd12, 5'd12);
    to_mid();
    check("dual_bypass_p1", bus.rd_data1, 32'h0000_0001);
    check("dual_bypass_p2", bus.rd_data2, 32'h0000_0001);
    next_edge();
    drive(1'b1, 1'b1, 5'd12, 32'h0000_0002, 5'd12, 5'd0);
    to_mid();
    check("b2b_bypass", bus.rd_data1, 32'h0000_0002);
    next_edge();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
    to_mid();
    check("b2b_last_wins", bus.rd_data1, 32'h0000_0002);
    next_edge();

    // 6) load 10 registers, then reset together with a write to 3
    for (int i = 1; i <= 10; i++) write_reg(5'(i), 32'hA000_0000 + 32'(i));
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd3);
    to_mid();
    check("loaded_r10", bus.rd_data1, 32'hA000_000A);
    check("loaded_r3", bus.rd_data2, 32'hA000_0003);
    next_edge();
    drive(1'b0, 1'b1, 5'd3, 32'h0000_CAFE, 5'd3, 5'd30);
    to_mid();
    check("rst_no_bypass", bus.rd_data1, 32'hA000_0003);
    check("rst_cycle_sp", bus.rd_data2, 32'hA000_0000 + 32'd0 + 32'h0 == 32'h0 ? 32'h0 : 32'h0000_03FC);
    next_edge();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      to_mid();
      check("post_rst_p1", bus.rd_data1, (i == 30) ? 32'h0000_03FC : 32'h0);
      check("post_rst_p2", bus.rd_data2, (i == 1) ? 32'h0000_03FC : 32'h0);
      next_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

Architectural register file for the pRISC datapath: 32 general-purpose registers, two combinational read ports and one synchronous write port. It sits directly downstream of the 5-bit 3-to-1 write-address selector (rd / rt / return-address 31). That selector's output drives `wr_addr` here, and the write-back value drives `wr_data`. Read ports feed the ALU operand path in the same cycle as decode. The block is written as a plain register file, but it owns the reset state of the machine and the write-to-read bypass.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register index width (32 registers).
- `SP_IDX`, 30: index of the stack-pointer register.
- `SP_RESET`, 32'h0000_03FC: reset value of the stack pointer (top word of 1 KB data memory).
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `rd_addr1`  in  ADDR_W: read port 1 index.
- `rd_addr2`  in  ADDR_W: read port 2 index.
- `rd_data1`  out  DATA_W: read port 1 data, combinational.
- `rd_data2`  out  DATA_W: read port 2 data, combinational.
- `wr_en`  in  1: write enable from the control unit.
- `wr_addr`  in  ADDR_W: write index, driven by the write-address selector.
- `wr_data`  in  DATA_W: write-back data.

## Operation
- Storage is 32 x `DATA_W` flops.
- There is no hardwired zero: register 0 is writable like any other.
- **Reset:** on a rising edge with `rst`=0, every register loads 0, except `SP_IDX`, which loads `SP_RESET`.
  - Reset has priority over any write in that cycle.
  - A write presented in the reset cycle is discarded.
- **Write:** on a rising edge with `rst`=1 and `wr_en`=1, `regs[wr_addr]` <= `wr_data`.
  - With `wr_en`=0, no register changes.
- **Read:** `rd_dataN` = `regs[rd_addrN]`, purely combinational.
- **Bypass:** if `rst`=1, `wr_en`=1 and `wr_addr`==`rd_addrN`, then `rd_dataN` = `wr_data` in the same cycle (write-before-read).
  - Each port is bypassed independently; both ports may bypass at once.
  - The bypass is disabled while `rst`=0.
- Both read ports may address the same register.
- All index values 0..31 are legal; there is no out-of-range case.

## Timing
- Read latency: 0 cycles (combinational from `rd_addrN` and register state).
- Write latency: 1 edge. The value is visible through the array on the cycle after the edge, and through the bypass in the same cycle.
- Output values after reset:
  - `rd_dataN` = 0 for any address other than `SP_IDX`.
  - `rd_dataN` = `SP_RESET` for `SP_IDX`.
- Reset asserted mid-program: state is discarded at the next edge. There is no partial write, because reset wins.
- Back-to-back writes to the same index: the last edge wins, and the bypass always reflects the current-cycle `wr_data`.

## Structure
- Shared package `prisc_pkg` holds:
  - `REG_COUNT`=32, `ADDR_W`, `DATA_W`;
  - named indices `RA_IDX`=31 and `SP_IDX`=30;
  - `SP_RESET`.
  The write-address selector and the control unit use the same `RA_IDX` constant.
- One natural sub-module: `reg_read_port`, which does the array index plus the bypass compare/mux and is instantiated twice. Everything else stays in `reg_file`.

## Test plan
1. Reset, then sweep `rd_addr1` over 0..31 -> 0 everywhere except index 30, which reads 32'h0000_03FC.
2. Write 32'hDEAD_BEEF to index 31 (`wr_en`=1), then next cycle read 31 on both ports -> both 32'hDEAD_BEEF.
3. Same cycle: `wr_addr`=5, `wr_data`=32'h1234_5678, `rd_addr1`=5, `rd_addr2`=6 -> `rd_data1`=32'h1234_5678 via bypass, `rd_data2`=old value of 6.
4. `wr_en`=0 with `wr_addr`=7, `wr_data`=32'hFFFF_FFFF -> register 7 unchanged, and no bypass seen on a port reading 7.
5. Write to register 0 with 32'h0000_0042, then read 0 -> 32'h0000_0042 (no hardwired zero).
6. Load 10 registers with distinct values, then assert `rst`=0 together with `wr_en`=1, `wr_addr`=3 -> after the edge all registers are reset values, register 3 = 0, and `rd_data` shows no bypass during the reset cycle.
